// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtract controller.
// Encoding 2'd3 is unused and treated as IDLE by every decoder.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Any state that is neither RUN nor DONE behaves as IDLE.
    function automatic logic is_idle(input state_e s);
        return (s != RUN) && (s != DONE);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Producer/consumer handshake and operand/result bus for serial_sub_ctrl.
// The master drives operands and out_ready; the slave returns status and the result.
interface serial_sub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow_out, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow_out, busy
    );
endinterface

// File: rtl/fullsub_cell.sv
// Purely combinational 1-bit full subtractor: x - y - c -> difference d, borrow bo.
module fullsub_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fullsub_cell walked LSB-first over WIDTH bits with a
// registered borrow, wrapped in a valid/ready IDLE -> RUN -> DONE controller.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_sub_ctrl_if.slave  bus
);
    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              brw_q, brw_d;
    logic              borrow_q, borrow_d;
    logic              cell_d, cell_bo;

    fullsub_cell u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .c  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        case (state_q)
            RUN: begin
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                brw_d  = cell_bo;
                if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    borrow_d = cell_bo;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                // diff is deliberately left alone on accept; it is rebuilt bit by bit.
                if (bus.in_valid) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
        end
    end

    // Status outputs decode the state register only, never the inputs.
    assign bus.in_ready   = is_idle(state_q);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = !is_idle(state_q);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: WIDTH=8 and WIDTH=2 instances, result
// scoreboards popped on each output handshake, plus reset/backpressure/streaming sequences.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc8 = 0;

    serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_sub_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_sub_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bo;
    } vec8_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       bin;
        logic [2:0] res;
    } vec2_t;

    vec8_t      tab8[8];
    vec2_t      tab2[32];
    logic [8:0] sb8[$];
    logic [2:0] sb2[$];
    logic [8:0] e8;
    logic [2:0] e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards: compare on the negedge before the handshake edge.
    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res8_unexpected: got %0h expected none", {bus8.borrow_out, bus8.diff});
            end else begin
                e8 = sb8.pop_front();
                check("res8", 64'({bus8.borrow_out, bus8.diff}), 64'(e8));
            end
        end
        if (!rst && bus2.out_valid && bus2.out_ready) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res2_unexpected: got %0h expected none", {bus2.borrow_out, bus2.diff});
            end else begin
                e2 = sb2.pop_front();
                check("res2", 64'({bus2.borrow_out, bus2.diff}), 64'(e2));
            end
        end
    end

    // Called at a negedge; returns on the negedge after the accept edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [8:0] exp, input logic hold);
        int w = 0;
        bus8.a = a;
        bus8.b = b;
        bus8.bin = bin;
        bus8.in_valid = 1'b1;
        while (!bus8.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout: got in_ready=0 expected 1");
        end else begin
            sb8.push_back(exp);
            acc8 = cyc + 1;
        end
        @(negedge clk);
        if (!hold) bus8.in_valid = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send2(input logic [1:0] a, input logic [1:0] b, input logic bin,
                         input logic [2:0] exp);
        int w = 0;
        bus2.a = a;
        bus2.b = b;
        bus2.bin = bin;
        bus2.in_valid = 1'b1;
        while (!bus2.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL send2_timeout: got in_ready=0 expected 1");
        end else begin
            sb2.push_back(exp);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p;
        int w;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.bin = 1'b0; bus2.out_ready = 1'b1;

        tab8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        tab8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        tab8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        tab8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tab8[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        tab8[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
        tab8[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        tab8[7] = '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0};
        for (int i = 0; i < 32; i++) begin
            tab2[i].a   = 2'(i >> 3);
            tab2[i].b   = 2'(i >> 1);
            tab2[i].bin = i[0];
            tab2[i].res = 3'({1'b0, tab2[i].a} - {1'b0, tab2[i].b} - {2'b00, tab2[i].bin});
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus8.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus8.out_valid), 64'(0));
        check("rst_busy", 64'(bus8.busy), 64'(0));
        check("rst_result", 64'({bus8.borrow_out, bus8.diff}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 vectors
        for (int i = 0; i < 8; i++) begin
            send8(tab8[i].a, tab8[i].b, tab8[i].bin, {tab8[i].bo, tab8[i].diff}, 1'b0);
            check("run_busy", 64'(bus8.busy), 64'(1));
            check("run_in_ready", 64'(bus8.in_ready), 64'(0));
            wait_done8(lat);
            check("lat8", 64'(lat), 64'(8));
        end

        // Exhaustive WIDTH=2
        for (int i = 0; i < 32; i++) begin
            send2(tab2[i].a, tab2[i].b, tab2[i].bin, tab2[i].res);
            lat = 0;
            while (!bus2.out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check("lat2", 64'(lat), 64'(2));
        end
        @(negedge clk);

        // Backpressure with ignored operands
        bus8.out_ready = 1'b0;
        send8(8'h40, 8'h01, 1'b1, {1'b0, 8'h3E}, 1'b0);
        wait_done8(lat);
        check("bp_lat", 64'(lat), 64'(8));
        for (int k = 0; k < 5; k++) begin
            bus8.in_valid = 1'b1;
            bus8.a = 8'h77;
            bus8.b = 8'h11;
            @(negedge clk);
            check("bp_out_valid", 64'(bus8.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus8.in_ready), 64'(0));
            check("bp_result", 64'({bus8.borrow_out, bus8.diff}), 64'({1'b0, 8'h3E}));
        end
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1 bus8.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle", 64'({bus8.in_ready, bus8.busy}), 64'(2'b10));
        check("bp_sb_empty", 64'(sb8.size()), 64'(0));

        // Reset in the middle of RUN
        send8(8'h12, 8'h34, 1'b0, 9'h000, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb8.delete();
        check("mid_rst_in_ready", 64'(bus8.in_ready), 64'(1));
        check("mid_rst_out_valid", 64'(bus8.out_valid), 64'(0));
        check("mid_rst_busy", 64'(bus8.busy), 64'(0));
        check("mid_rst_result", 64'({bus8.borrow_out, bus8.diff}), 64'(0));
        repeat (10) @(negedge clk);
        check("mid_rst_no_valid", 64'(bus8.out_valid), 64'(0));
        send8(8'hA0, 8'h0F, 1'b0, {1'b0, 8'h91}, 1'b0);
        wait_done8(lat);
        check("post_rst_lat", 64'(lat), 64'(8));
        @(negedge clk);

        // Back-to-back with in_valid held high
        send8(8'h10, 8'h01, 1'b0, {1'b0, 8'h0F}, 1'b1);
        p = acc8;
        send8(8'h01, 8'h02, 1'b1, {1'b1, 8'hFE}, 1'b1);
        check("b2b_spacing1", 64'(acc8 - p), 64'(10));
        p = acc8;
        send8(8'hC3, 8'h3C, 1'b0, {1'b0, 8'h87}, 1'b0);
        check("b2b_spacing2", 64'(acc8 - p), 64'(10));

        w = 0;
        while ((sb8.size() != 0 || sb2.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("sb_drain", 64'(sb8.size() + sb2.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
